// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/pc_incrementer.sv
// rtl/pc_incrementer.sv - combinational PC + WORD_BYTES incrementer
// Every carry into the word-index bits is formed directly from the lower bits (lookahead).
module pc_incrementer
  import mips_pkg::*;
(
  input  word_t a,
  output word_t y
);

  localparam int LSB = $clog2(WORD_BYTES);
  localparam int HW  = 32 - LSB;

  logic [HW-1:0] hi;
  logic [HW-1:0] carry;

  assign hi       = a[31:LSB];
  assign carry[0] = 1'b1;

  for (genvar i = 1; i < HW; i++) begin : g_carry
    assign carry[i] = &hi[i-1:0];
  end

  assign y = {hi ^ carry, a[LSB-1:0]};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch-stage program counter and next-PC selection
// Handles boot bubble, stall hold, jump/branch redirects with flush bubbles and a redirect counter.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  input  logic                 Jump,
  input  logic [31:0]          JumpTarget,
  input  logic                 ImemReady,
  output logic [31:0]          PCResult,
  output logic [31:0]          PCAddResult,
  output logic                 FetchValid,
  output logic                 Flush,
  output logic                 AlignErr,
  output logic [CNT_WIDTH-1:0] RedirectCount
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pc_state_e            state_q, state_d;
  word_t                pc_q, pc_d;
  logic [2:0]           flush_cnt_q, flush_cnt_d;
  logic                 align_err_q, align_err_d;
  logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;

  word_t pc_add;
  word_t target;
  logic  redirect;
  logic  fetch_valid;
  logic  flush;

  pc_incrementer u_inc (
    .a (pc_q),
    .y (pc_add)
  );

  assign redirect = Jump | BranchTaken;
  assign target   = Jump ? JumpTarget : BranchTarget;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    flush_cnt_d      = flush_cnt_q;
    align_err_d      = 1'b0;
    redirect_count_d = redirect_count_q;
    fetch_valid      = 1'b0;
    flush            = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        fetch_valid = ImemReady & ~Stall;
        if (fetch_valid) pc_d = pc_add;
      end
      FLUSH: begin
        flush       = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    // A redirect outranks stall, imem back-pressure and any in-progress flush.
    if (state_q != BOOT && redirect) begin
      pc_d        = {target[31:2], 2'b00};
      align_err_d = |target[1:0];
      if (redirect_count_q != '1) redirect_count_d = redirect_count_q + CNT_WIDTH'(1);
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      flush_cnt_q      <= 3'd0;
      align_err_q      <= 1'b0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      flush_cnt_q      <= flush_cnt_d;
      align_err_q      <= align_err_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign PCResult      = pc_q;
  assign PCAddResult   = pc_add;
  assign FetchValid    = fetch_valid;
  assign Flush         = flush;
  assign AlignErr      = align_err_q;
  assign RedirectCount = redirect_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
// Two instances (default and FLUSH_CYCLES=3/CNT_WIDTH=2) are checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV_B = 32'h0000_1000;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, Stall, BranchTaken, Jump, ImemReady;
  logic [31:0] BranchTarget, JumpTarget;

  logic [31:0] pc_a, pca_a, pc_b, pca_b;
  logic        fv_a, fl_a, ae_a, fv_b, fl_b, ae_b;
  logic [15:0] rc_a;
  logic [1:0]  rc_b;

  pc_sequencer dut_a (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .ImemReady(ImemReady), .PCResult(pc_a), .PCAddResult(pca_a),
    .FetchValid(fv_a), .Flush(fl_a), .AlignErr(ae_a), .RedirectCount(rc_a)
  );

  pc_sequencer #(.RESET_VECTOR(RV_B), .FLUSH_CYCLES(3), .CNT_WIDTH(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .ImemReady(ImemReady), .PCResult(pc_b), .PCAddResult(pca_b),
    .FetchValid(fv_b), .Flush(fl_b), .AlignErr(ae_b), .RedirectCount(rc_b)
  );

  // Behavioural model: boot flag, bubbles still owed, and the architectural PC.
  logic [31:0] rv[2]   = '{32'h0, RV_B};
  int          fc[2]   = '{1, 3};
  int          cmax[2] = '{65535, 3};
  logic [31:0] m_pc[2];
  int          m_bub[2];
  bit          m_boot[2];
  bit          m_ae[2];
  int          m_cnt[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        m_pc[k] = rv[k]; m_bub[k] = 0; m_boot[k] = 1; m_ae[k] = 0; m_cnt[k] = 0;
      end else if (m_boot[k]) begin
        m_boot[k] = 0; m_ae[k] = 0;
      end else if (Jump || BranchTaken) begin
        tgt      = Jump ? JumpTarget : BranchTarget;
        m_ae[k]  = (tgt % 4) != 0;
        m_pc[k]  = tgt - (tgt % 4);
        m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
        m_bub[k] = fc[k];
      end else begin
        m_ae[k] = 0;
        if (m_bub[k] > 0) m_bub[k]--;
        else if (ImemReady && !Stall) m_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    logic exp_fv[2];
    for (int k = 0; k < 2; k++)
      exp_fv[k] = !m_boot[k] && m_bub[k] == 0 && ImemReady && !Stall;
    chk("a.PCResult",      pc_a,          m_pc[0]);
    chk("a.PCAddResult",   pca_a,         m_pc[0] + 32'd4);
    chk("a.FetchValid",    32'(fv_a),     32'(exp_fv[0]));
    chk("a.Flush",         32'(fl_a),     32'(m_bub[0] > 0));
    chk("a.AlignErr",      32'(ae_a),     32'(m_ae[0]));
    chk("a.RedirectCount", 32'(rc_a),     32'(m_cnt[0]));
    chk("b.PCResult",      pc_b,          m_pc[1]);
    chk("b.PCAddResult",   pca_b,         m_pc[1] + 32'd4);
    chk("b.FetchValid",    32'(fv_b),     32'(exp_fv[1]));
    chk("b.Flush",         32'(fl_b),     32'(m_bub[1] > 0));
    chk("b.AlignErr",      32'(ae_b),     32'(m_ae[1]));
    chk("b.RedirectCount", 32'(rc_b),     32'(m_cnt[1]));
  endtask

  task automatic do_cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      #1;
      check_all();
      @(posedge Clk);
      model_step();
      #1;
    end
  endtask

  task automatic set_in(input logic rst, input logic stall, input logic ready,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
    Rst = rst; Stall = stall; ImemReady = ready;
    BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
  endtask

  initial begin
    set_in(1, 0, 1, 0, 0, 0, 0);
    @(posedge Clk);
    model_step();
    #1;
    do_cycle(1);

    // Reset release, boot bubble, then sequential fetch 0,4,8,12
    set_in(0, 0, 1, 0, 0, 0, 0);
    do_cycle(1);
    chk("boot.FetchValid_after", 32'(fv_a), 32'd1);
    do_cycle(4);
    chk("seq.pc16", pc_a, 32'h10);

    // Stall three cycles at 0x10
    Stall = 1;
    do_cycle(3);
    chk("stall.pc_held", pc_a, 32'h10);
    Stall = 0;
    do_cycle(1);
    chk("stall.pc14", pc_a, 32'h14);
    do_cycle(3);
    chk("pre_branch.pc20", pc_a, 32'h20);

    // Branch accepted while stalled
    set_in(0, 1, 1, 1, 32'h400, 0, 0);
    do_cycle(1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("branch.pc", pc_a, 32'h400);
    chk("branch.flush", 32'(fl_a), 32'd1);
    chk("branch.count", 32'(rc_a), 32'd1);
    do_cycle(2);

    // Jump and branch together: jump wins, single count
    set_in(0, 0, 1, 1, 32'h400, 1, 32'h800);
    do_cycle(1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("jb.pc_b", pc_b, 32'h800);
    chk("jb.count_b", 32'(rc_b), 32'd2);
    do_cycle(3);
    chk("jb.flush_done_b", 32'(fl_b), 32'd0);

    // Misaligned target, then redirect mid-flush
    set_in(0, 0, 1, 0, 0, 1, 32'h103);
    do_cycle(1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("align.pc", pc_a, 32'h100);
    chk("align.err", 32'(ae_a), 32'd1);
    do_cycle(1);
    set_in(0, 0, 1, 1, 32'h200, 0, 0);
    do_cycle(1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("reflush.pc_b", pc_b, 32'h200);
    do_cycle(2);
    chk("reflush.still_b", 32'(fl_b), 32'd1);
    do_cycle(2);

    // Wrap past the top of the address space
    set_in(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    do_cycle(1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    do_cycle(1);
    chk("wrap.pcadd", pca_a, 32'h0);
    do_cycle(1);
    chk("wrap.pc", pc_a, 32'h0);

    // Saturating counter and reset during flush
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 0, 0, 1, $urandom & 32'hFFFF_FFFC);
      do_cycle(1);
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("sat.count_b", 32'(rc_b), 32'd3);
    chk("sat.flush_b", 32'(fl_b), 32'd1);
    Rst = 1;
    do_cycle(1);
    Rst = 0;
    chk("rst.pc_b", pc_b, RV_B);
    chk("rst.flush_b", 32'(fl_b), 32'd0);
    do_cycle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0,
             ($urandom % 8) == 0, $urandom, ($urandom % 10) == 0, $urandom);
      do_cycle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
